icache_axi_refill_master: RTL and testbench

//  Downstream neighbour of the L1 instruction cache, inside the CPU wrapper on master port M0.

---
 rtl/icache_axi_refill_master_pkg.sv | 15 +
 rtl/icache_axi_refill_master.sv | 158 +++++++++++++++
 tb/tb_icache_axi_refill_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_axi_refill_master_pkg.sv
// Shared AXI encodings and the refill FSM state type for the I-cache refill master.
package icache_axi_refill_master_pkg;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDone
  } refill_state_e;

endpackage

// File: rtl/icache_axi_refill_master.sv
// Turns an I-cache line-refill request into one INCR AXI read burst and returns
// each beat to the cache with I_wait low for exactly that cycle.
module icache_axi_refill_master
  import icache_axi_refill_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter logic [ID_W-1:0] M_ID = '0,
  parameter int unsigned BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic              I_write,
  output logic [DATA_W-1:0] I_out,
  output logic              I_wait,
  output logic [ID_W-1:0]   ARID_M0,
  output logic [ADDR_W-1:0] ARADDR_M0,
  output logic [7:0]        ARLEN_M0,
  output logic [2:0]        ARSIZE_M0,
  output logic [1:0]        ARBURST_M0,
  output logic              ARVALID_M0,
  input  logic              ARREADY_M0,
  input  logic [ID_W-1:0]   RID_M0,
  input  logic [DATA_W-1:0] RDATA_M0,
  input  logic [1:0]        RRESP_M0,
  input  logic              RLAST_M0,
  input  logic              RVALID_M0,
  output logic              RREADY_M0,
  output logic              refill_err
);

  localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  refill_state_e     state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic              drain_q, drain_d;
  logic              beat, id_ok, at_last, deliver;

  // Offset bits inside the line are discarded by the alignment below.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^I_addr[3:0];

  assign beat    = RVALID_M0 && rready_q;
  assign id_ok   = (RID_M0 == M_ID);
  assign at_last = (beat_cnt_q == LastBeat);

  always_comb begin
    state_d    = state_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    araddr_d   = araddr_q;
    beat_cnt_d = beat_cnt_q;
    drain_d    = drain_q;
    err_d      = 1'b0;
    deliver    = 1'b0;
    I_wait     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Drop trailing beats of a burst that overran its length.
        if (drain_q && beat && RLAST_M0) begin
          drain_d  = 1'b0;
          rready_d = 1'b0;
        end
        if (I_req) begin
          if (I_write) begin
            err_d = 1'b1;
          end else if (drain_q) begin
            I_wait = 1'b1;
          end else begin
            I_wait    = 1'b1;
            araddr_d  = {I_addr[ADDR_W-1:4], 4'b0000};
            arvalid_d = 1'b1;
            state_d   = StAddr;
          end
        end
      end

      StAddr: begin
        I_wait = 1'b1;
        if (ARREADY_M0) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StData;
        end
      end

      StData: begin
        I_wait = 1'b1;
        if (beat) begin
          if (!id_ok) begin
            // Foreign ID: consume the beat but never hand it to the cache.
            err_d = 1'b1;
          end else begin
            deliver    = 1'b1;
            I_wait     = 1'b0;
            beat_cnt_d = beat_cnt_q + CntW'(1);
            if (RRESP_M0 != AXI_RESP_OKAY) err_d = 1'b1;
            if (RLAST_M0 != at_last) err_d = 1'b1;
            if (RLAST_M0 || at_last) begin
              rready_d   = 1'b0;
              beat_cnt_d = '0;
              drain_d    = !RLAST_M0;
              state_d    = StDone;
            end
          end
        end
      end

      StDone: begin
        rready_d = drain_q;
        state_d  = StIdle;
      end

      default: state_d = StIdle;
    endcase

    I_out = deliver ? RDATA_M0 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      drain_q    <= drain_d;
    end
  end

  assign ARID_M0    = M_ID;
  assign ARADDR_M0  = araddr_q;
  assign ARLEN_M0   = 8'(BEATS - 1);
  assign ARSIZE_M0  = AXI_SIZE_WORD;
  assign ARBURST_M0 = AXI_BURST_INCR;
  assign ARVALID_M0 = arvalid_q;
  assign RREADY_M0  = rready_q;
  assign refill_err = err_q;

endmodule

// File: tb/tb_icache_axi_refill_master.sv
// Self-checking bench for icache_axi_refill_master: scripted AXI slave, delivery scoreboard.
module tb_icache_axi_refill_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_req;
  logic [31:0] I_addr;
  logic        I_write;
  logic [31:0] I_out;
  logic        I_wait;
  logic [3:0]  ARID_M0;
  logic [31:0] ARADDR_M0;
  logic [7:0]  ARLEN_M0;
  logic [2:0]  ARSIZE_M0;
  logic [1:0]  ARBURST_M0;
  logic        ARVALID_M0;
  logic        ARREADY_M0;
  logic [3:0]  RID_M0;
  logic [31:0] RDATA_M0;
  logic [1:0]  RRESP_M0;
  logic        RLAST_M0;
  logic        RVALID_M0;
  logic        RREADY_M0;
  logic        refill_err;

  icache_axi_refill_master dut (
    .clk        (clk),
    .rst        (rst),
    .I_req      (I_req),
    .I_addr     (I_addr),
    .I_write    (I_write),
    .I_out      (I_out),
    .I_wait     (I_wait),
    .ARID_M0    (ARID_M0),
    .ARADDR_M0  (ARADDR_M0),
    .ARLEN_M0   (ARLEN_M0),
    .ARSIZE_M0  (ARSIZE_M0),
    .ARBURST_M0 (ARBURST_M0),
    .ARVALID_M0 (ARVALID_M0),
    .ARREADY_M0 (ARREADY_M0),
    .RID_M0     (RID_M0),
    .RDATA_M0   (RDATA_M0),
    .RRESP_M0   (RRESP_M0),
    .RLAST_M0   (RLAST_M0),
    .RVALID_M0  (RVALID_M0),
    .RREADY_M0  (RREADY_M0),
    .refill_err (refill_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          deliveries = 0;
  int          err_cycles = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  // Inputs change 1 time unit after posedge; everything is sampled on the negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (refill_err === 1'b1) err_cycles++;
      if (I_wait === 1'b0 && RVALID_M0 === 1'b1 && RREADY_M0 === 1'b1) begin
        deliveries++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL deliver_unexpected: got I_out=%h, required no delivery", I_out);
        end else begin
          mon_exp = exp_q.pop_front();
          if (I_out !== mon_exp) begin
            bad++;
            $display("FAIL deliver_data: got I_out=%h, required %h", I_out, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] beat_data(input logic [31:0] addr, input int i);
    return {addr[23:4], 4'h0, 8'(i)} ^ 32'hA500_0000;
  endfunction

  // Request a line, answer AR after ar_delay stall cycles, then drive n_beats R beats.
  task automatic run_burst(input logic [31:0] addr, input int ar_delay, input bit gapped,
                           input int n_beats, input int slverr_idx, input int bad_id_idx,
                           input int last_idx, input int exp_err);
    logic [31:0] exp_addr;
    int          exp_deliv;
    exp_addr   = {addr[31:4], 4'b0000};
    exp_deliv  = 0;
    deliveries = 0;
    err_cycles = 0;
    @(posedge clk); #1;
    I_req = 1'b1; I_addr = addr; I_write = 1'b0;
    #1;
    total++;
    if (I_wait !== 1'b1) begin
      bad++; $display("FAIL req_wait: got I_wait=%b, required 1", I_wait);
    end
    @(posedge clk); #1;
    total++;
    if (ARVALID_M0 !== 1'b1 || ARADDR_M0 !== exp_addr || ARLEN_M0 !== 8'd3 ||
        ARSIZE_M0 !== 3'b010 || ARBURST_M0 !== 2'b01 || ARID_M0 !== 4'h0) begin
      bad++;
      $display("FAIL ar_fields: got valid=%b addr=%h len=%h size=%b burst=%b id=%h, required 1 %h 03 010 01 0",
               ARVALID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARID_M0, exp_addr);
    end
    I_req = 1'b0;
    for (int d = 0; d < ar_delay; d++) begin
      @(posedge clk); #1;
      total++;
      if (ARVALID_M0 !== 1'b1 || ARADDR_M0 !== exp_addr || ARLEN_M0 !== 8'd3 || I_wait !== 1'b1) begin
        bad++;
        $display("FAIL ar_stable: got valid=%b addr=%h len=%h wait=%b, required 1 %h 03 1",
                 ARVALID_M0, ARADDR_M0, ARLEN_M0, I_wait, exp_addr);
      end
    end
    ARREADY_M0 = 1'b1;
    @(posedge clk); #1;
    ARREADY_M0 = 1'b0;
    total++;
    if (ARVALID_M0 !== 1'b0 || RREADY_M0 !== 1'b1) begin
      bad++;
      $display("FAIL ar_handshake: got arvalid=%b rready=%b, required 0 1", ARVALID_M0, RREADY_M0);
    end
    for (int i = 0; i < n_beats; i++) begin
      RVALID_M0 = 1'b1;
      RDATA_M0  = beat_data(addr, i);
      RID_M0    = (i == bad_id_idx) ? 4'h5 : 4'h0;
      RRESP_M0  = (i == slverr_idx) ? 2'b10 : 2'b00;
      RLAST_M0  = (i == last_idx);
      if (i != bad_id_idx) begin
        exp_q.push_back(beat_data(addr, i));
        exp_deliv++;
      end
      total++;
      if (RREADY_M0 !== 1'b1) begin
        bad++; $display("FAIL beat_ready: beat %0d got RREADY=%b, required 1", i, RREADY_M0);
      end
      @(posedge clk); #1;
      RVALID_M0 = 1'b0;
      RLAST_M0  = 1'b0;
      if (gapped && i < n_beats - 1) begin
        #1;
        total++;
        if (I_wait !== 1'b1) begin
          bad++; $display("FAIL gap_wait: got I_wait=%b, required 1", I_wait);
        end
        @(posedge clk); #1;
      end
    end
    #1;
    total++;
    if (I_wait !== 1'b0 || RREADY_M0 !== 1'b0 || ARVALID_M0 !== 1'b0) begin
      bad++;
      $display("FAIL done_state: got wait=%b rready=%b arvalid=%b, required 0 0 0",
               I_wait, RREADY_M0, ARVALID_M0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (deliveries != exp_deliv || exp_q.size() != 0) begin
      bad++;
      $display("FAIL deliver_count: got %0d deliveries (%0d pending), required %0d",
               deliveries, exp_q.size(), exp_deliv);
    end
    total++;
    if (err_cycles != exp_err) begin
      bad++; $display("FAIL err_pulse: got %0d refill_err cycles, required %0d", err_cycles, exp_err);
    end
    total++;
    if (I_wait !== 1'b0 || ARVALID_M0 !== 1'b0 || RREADY_M0 !== 1'b0) begin
      bad++;
      $display("FAIL back_idle: got wait=%b arvalid=%b rready=%b, required 0 0 0",
               I_wait, ARVALID_M0, RREADY_M0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ARVALID_M0 !== 1'b0 || RREADY_M0 !== 1'b0 || ARADDR_M0 !== 32'h0 ||
        refill_err !== 1'b0 || I_out !== 32'h0 || I_wait !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got arvalid=%b rready=%b araddr=%h err=%b out=%h wait=%b, required 0 0 0 0 0 0",
               ARVALID_M0, RREADY_M0, ARADDR_M0, refill_err, I_out, I_wait);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_burst(32'h0000_1234, 0, 1'b0, 4, -1, -1, 3, 0);
  endtask

  task automatic test_backpressure();
    run_burst(32'h8000_0ABC, 5, 1'b1, 4, -1, -1, 3, 0);
  endtask

  task automatic test_slverr();
    run_burst(32'h0000_2040, 0, 1'b0, 4, 2, -1, 3, 1);
  endtask

  task automatic test_early_last();
    run_burst(32'h0000_3000, 1, 1'b0, 2, -1, -1, 1, 1);
  endtask

  task automatic test_bad_id();
    run_burst(32'h0001_5558, 0, 1'b0, 5, -1, 2, 4, 1);
  endtask

  task automatic test_reset_mid_burst();
    @(posedge clk); #1;
    I_req = 1'b1; I_addr = 32'h0000_4444; I_write = 1'b0;
    @(posedge clk); #1;
    I_req = 1'b0; ARREADY_M0 = 1'b1;
    @(posedge clk); #1;
    ARREADY_M0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      RVALID_M0 = 1'b1; RDATA_M0 = beat_data(32'h0000_4444, i);
      RID_M0 = 4'h0; RRESP_M0 = 2'b00; RLAST_M0 = 1'b0;
      exp_q.push_back(beat_data(32'h0000_4444, i));
      @(posedge clk); #1;
    end
    RVALID_M0 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ARVALID_M0 !== 1'b0 || RREADY_M0 !== 1'b0 || I_wait !== 1'b0 || refill_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got arvalid=%b rready=%b wait=%b err=%b, required 0 0 0 0",
               ARVALID_M0, RREADY_M0, I_wait, refill_err);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL reset_mid_beats: got %0d undelivered beats, required 0", exp_q.size());
    end
    rst = 1'b0;
    run_burst(32'h0000_6660, 0, 1'b0, 4, -1, -1, 3, 0);
  endtask

  task automatic test_write_err();
    err_cycles = 0;
    @(posedge clk); #1;
    I_req = 1'b1; I_write = 1'b1; I_addr = 32'h0000_7770;
    #1;
    total++;
    if (I_wait !== 1'b0) begin
      bad++; $display("FAIL write_wait: got I_wait=%b, required 0", I_wait);
    end
    @(posedge clk); #1;
    I_req = 1'b0; I_write = 1'b0;
    total++;
    if (ARVALID_M0 !== 1'b0 || refill_err !== 1'b1) begin
      bad++;
      $display("FAIL write_err: got arvalid=%b err=%b, required 0 1", ARVALID_M0, refill_err);
    end
    @(posedge clk); #1;
    total++;
    if (refill_err !== 1'b0 || err_cycles != 1) begin
      bad++;
      $display("FAIL write_err_pulse: got err=%b cycles=%0d, required 0 1", refill_err, err_cycles);
    end
  endtask

  initial begin
    rst = 1'b1; I_req = 1'b0; I_addr = '0; I_write = 1'b0;
    ARREADY_M0 = 1'b0; RID_M0 = '0; RDATA_M0 = '0; RRESP_M0 = '0;
    RLAST_M0 = 1'b0; RVALID_M0 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_slverr();
    test_early_last();
    test_reset_mid_burst();
    test_bad_id();
    test_write_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
